// File: rtl/uart_tx_frame_controller_pkg.sv
// uart_pkg: shared definitions for the UART TX frame controller.
//   - uart_state_e    : frame state encoding
//   - UART_DATA_BITS  : data bits per frame
//   - UART_IDLE_LEVEL : line level while idle and during stop bits
//   - calc_bit_cycles / calc_timer_width : bit-period sizing helpers
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Clock cycles per bit period, integer truncation.
  function automatic int calc_bit_cycles(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

  // Counter width able to hold 0..bit_cycles-1; never narrower than 1 bit.
  function automatic int calc_timer_width(input int bit_cycles);
    return (bit_cycles > 2) ? $clog2(bit_cycles) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_frame_controller_if.sv
// Byte intake handshake between a producer and the UART TX frame controller.
//   txValid : producer offers txData
//   txData  : byte to send, sampled only on the handshake cycle
//   txReady : controller can accept a byte
// master modport = producer side, slave modport = controller side.
interface uart_tx_frame_controller_if;
  import uart_pkg::*;

  logic                      txValid;
  logic [UART_DATA_BITS-1:0] txData;
  logic                      txReady;

  modport master (output txValid, output txData, input txReady);
  modport slave  (input txValid, input txData, output txReady);

endinterface

// File: rtl/uart_tx_frame_controller_baud_timer.sv
// uart_baud_timer: shared bit-period timer for the UART TX frame controller.
// Counts 0..BitCycles-1 and wraps; bitEnd marks the last cycle of each period.
//   clock  : system clock
//   reset  : synchronous, active-high
//   clear  : restart the period (count returns to 0 on the next edge)
//   bitEnd : high during the last cycle of each bit period
module uart_baud_timer
  import uart_pkg::*;
#(
  parameter int BitCycles = 104
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic bitEnd
);

  localparam int           TimerW   = calc_timer_width(BitCycles);
  localparam logic [TimerW-1:0] LastCount = TimerW'(BitCycles - 1);

  logic [TimerW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || (count_q == LastCount)) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bitEnd = (count_q == LastCount);

endmodule

// File: rtl/uart_tx_frame_controller.sv
// uart_tx_frame_controller: sends one UART frame per accepted byte
// (start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits).
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : txValid / txData / txReady byte intake handshake
//   busy         : frame in progress
//   frameDone    : pulse on the last cycle of the last stop bit
//   tx           : registered serial line, idle high
// Optional feature macro: UART_TX_PARITY_EN adds a parity bit after the data
// bits (parameter ParityOdd: 0 = even, 1 = odd).
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line idle high, txReady asserted
// ST_START  | start bit (low) for one bit period
// ST_DATA   | data bits LSB-first, bit_idx counts 0..7
// ST_PARITY | parity bit (only with UART_TX_PARITY_EN)
// ST_STOP   | stop bit(s) high, bit_idx counts stop bits
module uart_tx_frame_controller
  import uart_pkg::*;
#(
  parameter int ClockFrequency = 1000000,
  parameter int BaudRate       = 9600,
  parameter int StopBits       = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit ParityOdd      = 1'b0
`endif
) (
  input  logic                        clock,
  input  logic                        reset,
  uart_tx_frame_controller_if.slave   bus,
  output logic                        busy,
  output logic                        frameDone,
  output logic                        tx
);

  localparam int BitCycles = calc_bit_cycles(ClockFrequency, BaudRate);
  localparam int IdxW      = $clog2(UART_DATA_BITS);

  localparam logic [IdxW-1:0] LastDataIdx = IdxW'(UART_DATA_BITS - 1);
  localparam logic [IdxW-1:0] LastStopIdx = IdxW'(StopBits - 1);

  if (BitCycles < 2) begin : g_bad_bit_cycles
    $error("uart_tx_frame_controller: ClockFrequency/BaudRate must be at least 2");
  end
  if ((StopBits != 1) && (StopBits != 2)) begin : g_bad_stop_bits
    $error("uart_tx_frame_controller: StopBits must be 1 or 2");
  end

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [IdxW-1:0]           bit_idx_q, bit_idx_d;
  logic                      tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  logic bit_end;
  logic timer_clear;

  uart_baud_timer #(
    .BitCycles (BitCycles)
  ) u_baud_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .bitEnd (bit_end)
  );

  // tx_d is the line level for the state being entered, so tx changes on the
  // same edge as the state and the line stays glitch-free.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    tx_d        = tx_q;
    timer_clear = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        tx_d = UART_IDLE_LEVEL;
        if (bus.txValid) begin
          state_d     = ST_START;
          shift_d     = bus.txData;
          bit_idx_d   = '0;
          tx_d        = ~UART_IDLE_LEVEL;
          timer_clear = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d    = (^bus.txData) ^ ParityOdd;
`endif
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LastDataIdx) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = ST_PARITY;
            tx_d      = parity_q;
`else
            state_d   = ST_STOP;
            tx_d      = UART_IDLE_LEVEL;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end

      ST_PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (bit_end) begin
          state_d = ST_STOP;
          tx_d    = UART_IDLE_LEVEL;
        end
`else
        // Unreachable without parity; recover to idle.
        state_d = ST_IDLE;
        tx_d    = UART_IDLE_LEVEL;
`endif
      end

      ST_STOP: begin
        if (bit_end) begin
          if (bit_idx_q == LastStopIdx) begin
            state_d   = ST_IDLE;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
        tx_d = UART_IDLE_LEVEL;
      end

      default: begin
        state_d   = ST_IDLE;
        bit_idx_d = '0;
        tx_d      = UART_IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign bus.txReady = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign tx          = tx_q;

  // Decoded from flops only (state, stop index, timer count), so it lines up
  // exactly with the last cycle of the last stop bit; reset forces IDLE and
  // therefore suppresses it on an aborted frame.
  assign frameDone = (state_q == ST_STOP) && bit_end && (bit_idx_q == LastStopIdx);

endmodule
